// File: rtl/div_signed_seq_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the FSM state encodings (also decoded by the CPU controller) and the default width.
// No ports; imported by div_signed_seq and div_signed_seq_step.
package div_signed_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_signed_seq_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: rem_i/quot_i current partial remainder and quotient shifter, dvsr_i divisor
//        magnitude; rem_o/quot_o the values after one shift-and-trial-subtract.
module div_signed_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;

  // rem < dvsr <= 2^(WIDTH-1) always holds, so the shifted remainder fits WIDTH bits.
  assign rem_sh = {rem_i[WIDTH-2:0], quot_i[WIDTH-1]};
  // One extra bit so the borrow out tells us whether the trial went negative.
  assign trial  = {1'b0, rem_sh} - {1'b0, dvsr_i};

  always_comb begin
    rem_o  = rem_sh;
    quot_o = {quot_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o     = trial[WIDTH-1:0];
      quot_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_signed_seq.sv
// Sequential signed divider for the HI/LO path: lo = quotient, hi = remainder (dividend sign).
// Latency: WIDTH+1 edges from accepted start to done; 1 edge for a zero divisor (div_zero).
// Backpressure: start is only sampled while busy==0; requests made while busy are dropped.
// Ports: clock, reset (async active-low), start, dividend, divisor in;
//        lo, hi (held results), busy, done, div_zero (one-cycle pulses) out.
module div_signed_seq
  import div_signed_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_rem, step_quot;

  div_signed_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = ST_ZERO;
          end else begin
            // The quotient register starts out holding the dividend magnitude; it is
            // shifted out into the remainder as quotient bits shift in.
            // |0x80..0| is 0x80..0, which is still correct as an unsigned magnitude.
            quot_d    = dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_d    = divisor[WIDTH-1]  ? -divisor  : divisor;
            rem_d     = '0;
            sgn_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sgn_rem_d = dividend[WIDTH-1];
            cnt_d     = CW'(WIDTH - 1);
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FIX: begin
        lo_d    = sgn_quo_q ? -quot_q : quot_q;
        hi_d    = sgn_rem_q ? -rem_q  : rem_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ZERO: begin
        // Results are left untouched so the controller sees the previous HI/LO.
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  // The done cycle is already IDLE, so a start there is accepted back-to-back.
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign lo       = lo_q;
  assign hi       = hi_q;

endmodule
